// File: rtl/check4_neighbor_filter.sv
// ---------------------------------------------------------------------------
// check4_neighbor_filter
//
// Streaming 4-neighbour local-maximum detector for 8-bit greyscale video.
// Each valid input pixel at raster position (r,c) produces exactly one output
// pixel. That output is the result for the centre pixel (r-1,c-1), with raster
// wrap into the previous frame. The result is 8'hFF when the centre exceeds its
// up/down/left/right neighbours by more than THRESH, and 8'h00 otherwise or on
// the frame border. The latency is fixed at 2 cycles, and gaps in the input are
// reproduced in the output.
//
// Ports
//   clk_10M   in   1  sole clock, rising edge
//   reset     in   1  synchronous, active-high
//   din       in   8  greyscale pixel, raster order
//   valid     in   1  din valid this cycle (no backpressure)
//   dout      out  8  feature pixel, 8'hFF or 8'h00 (hold when !validout)
//   validout  out  1  dout valid this cycle
// ---------------------------------------------------------------------------
module check4_neighbor_filter #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int THRESH = 16
) (
    input  logic       clk_10M,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       valid,
    output logic [7:0] dout,
    output logic       validout
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    // Pixels arriving during reset are discarded entirely.
    logic fire;
    assign fire = valid & ~reset;

    // Position of the next input pixel, plus stage-1 registers.
    logic [CW-1:0] col_q, col_d, prev_col_q, prev_col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    din_q, din_d;
    logic          border_q, border_d;
    logic          v1_q, v1_d;

    // Stage-2 window registers, output register and output valid.
    logic [7:0]    ctr_q, ctr_d, lft_q, lft_d, up_q, up_d, dn_q, dn_d;
    logic [7:0]    dout_q, dout_d;
    logic          validout_q, validout_d;

    // Registered read data of the two line buffers:
    // [0] = previous line (r-1), [1] = the line before that (r-2).
    logic [1:0][7:0] lb_rd;

    // Line 0 stores the incoming pixel at its own column (read-first).
    // Line 1 receives what line 0 returned on the previous accepted pixel,
    // written at that pixel's column. The write therefore lags by one pixel,
    // which keeps each buffer down to a single read and a single write port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [7:0]    mem [WIDTH];
            logic [7:0]    rd_q;
            logic [7:0]    wr_data;
            logic [CW-1:0] wr_addr;

            assign wr_data = (gi == 0) ? din   : lb_rd[0];
            assign wr_addr = (gi == 0) ? col_q : prev_col_q;

            always_ff @(posedge clk_10M) begin
                if (fire) begin
                    mem[wr_addr] <= wr_data;
                    rd_q         <= mem[col_q];
                end
            end

            assign lb_rd[gi] = rd_q;
        end
    endgenerate

    function automatic logic beats(input logic [7:0] c, input logic [7:0] n);
        return {1'b0, c} > ({1'b0, n} + 9'(THRESH));
    endfunction

    logic peak;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        prev_col_d = prev_col_q;
        din_d      = din_q;
        border_d   = border_q;
        v1_d       = fire;

        if (fire) begin
            prev_col_d = col_q;
            din_d      = din;
            // The centre is (row-1, col-1) with wrap. It lies on the border
            // exactly when the input column is 0 or 1, or the input row is 0 or 1.
            border_d   = (col_q <= CW'(1)) || (row_q <= RW'(1));
            if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Window during stage 2:
    //   right = lb_rd[0] (this pixel's line-0 read)
    //   centre, left, up, down = values captured on earlier accepted pixels
    always_comb begin
        peak = !border_q
            && beats(ctr_q, lb_rd[0]) && beats(ctr_q, lft_q)
            && beats(ctr_q, up_q)     && beats(ctr_q, dn_q);

        ctr_d      = ctr_q;
        lft_d      = lft_q;
        up_d       = up_q;
        dn_d       = dn_q;
        dout_d     = dout_q;
        validout_d = v1_q;

        if (v1_q) begin
            ctr_d  = lb_rd[0];
            lft_d  = ctr_q;
            up_d   = lb_rd[1];
            dn_d   = din_q;
            dout_d = peak ? 8'hFF : 8'h00;
        end
    end

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            prev_col_q <= '0;
            din_q      <= '0;
            border_q   <= 1'b1;
            v1_q       <= 1'b0;
            ctr_q      <= '0;
            lft_q      <= '0;
            up_q       <= '0;
            dn_q       <= '0;
            dout_q     <= '0;
            validout_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            prev_col_q <= prev_col_d;
            din_q      <= din_d;
            border_q   <= border_d;
            v1_q       <= v1_d;
            ctr_q      <= ctr_d;
            lft_q      <= lft_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            dout_q     <= dout_d;
            validout_q <= validout_d;
        end
    end

    assign dout     = dout_q;
    assign validout = validout_q;

endmodule

// File: tb/tb_check4_neighbor_filter.sv
// ---------------------------------------------------------------------------
// tb_check4_neighbor_filter
//
// Randomised self-checking bench for check4_neighbor_filter at 8x6 with a
// threshold of 16. A reference model keeps every pixel accepted since the
// last reset in a queue. It derives each expected output directly from the
// raster-index rule (centre = k-WIDTH-1). Scenario checks also cover output
// counts and the position of peak outputs.
// ---------------------------------------------------------------------------
module tb_check4_neighbor_filter;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int TH = 16;
    localparam int N  = W * H;

    logic       clk_10M = 1'b0;
    logic       reset   = 1'b1;
    logic       valid   = 1'b0;
    logic [7:0] din     = 8'h00;
    logic [7:0] dout;
    logic       validout;

    check4_neighbor_filter #(.WIDTH(W), .HEIGHT(H), .THRESH(TH)) dut (
        .clk_10M  (clk_10M),
        .reset    (reset),
        .din      (din),
        .valid    (valid),
        .dout     (dout),
        .validout (validout)
    );

    always #50 clk_10M = ~clk_10M;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int hist[$];
    bit ev1 = 1'b0, ev2 = 1'b0;
    int ed1 = 0, ed2 = 0;
    bit started = 1'b0;

    function automatic int ref_out(input int k);
        int g, r, c, p;
        g = k - W - 1;
        if (g < 0) return 0;
        r = (g / W) % H;
        c = g % W;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        p = hist[g];
        if (p > hist[g - W] + TH && p > hist[g + W] + TH &&
            p > hist[g - 1] + TH && p > hist[g + 1] + TH) return 255;
        return 0;
    endfunction

    // Expected output lags the sampled input by two rising edges.
    always @(posedge clk_10M) begin
        started = 1'b1;
        ev2 = ev1;
        ed2 = ed1;
        if (reset) begin
            hist.delete();
            ev1 = 1'b0;
            ev2 = 1'b0;
            ed1 = 0;
        end else begin
            ev1 = valid;
            if (valid) begin
                hist.push_back(int'(din));
                ed1 = ref_out(hist.size() - 1);
            end
        end
    end

    int out_count = 0;
    int ff_abs[$];

    always @(negedge clk_10M) begin
        if (started) begin
            check_eq("validout", int'(validout), int'(ev2));
            if (ev2) check_eq("dout", int'(dout), ed2);
            if (validout) begin
                if (dout == 8'hFF) ff_abs.push_back(out_count);
                out_count++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] img [N];

    task automatic cyc(input bit v, input logic [7:0] px);
        valid = v;
        din   = px;
        @(posedge clk_10M);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'($urandom));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cyc(1'($urandom), 8'($urandom));
        check_eq("rst_dout", int'(dout), 0);
        check_eq("rst_validout", int'(validout), 0);
        reset = 1'b0;
        valid = 1'b0;
    endtask

    task automatic fill(input logic [7:0] bg);
        for (int i = 0; i < N; i++) img[i] = bg;
    endtask

    task automatic set_px(input int r, input int c, input logic [7:0] v);
        img[r * W + c] = v;
    endtask

    task automatic send_frame(input int gap_pct);
        for (int i = 0; i < N; i++) begin
            while (int'($urandom_range(99)) < gap_pct) cyc(1'b0, 8'($urandom));
            cyc(1'b1, img[i]);
        end
    endtask

    task automatic run_frame(input string tag, input int gap_pct,
                             input int exp_ff, input int exp_idx);
        int base, nff;
        base = out_count;
        nff  = ff_abs.size();
        send_frame(gap_pct);
        idle(4);
        check_eq({tag, "_outs"}, out_count - base, N);
        check_eq({tag, "_ffs"}, ff_abs.size() - nff, exp_ff);
        if (exp_ff == 1 && ff_abs.size() > nff)
            check_eq({tag, "_idx"}, ff_abs[nff] - base, exp_idx);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base, nff;

        @(posedge clk_10M);
        #1;
        do_reset(3);

        // Latency: a single pulse emerges exactly two cycles later as border.
        cyc(1'b1, 8'hAB);
        check_eq("lat_vout_t1", int'(validout), 0);
        cyc(1'b0, 8'h00);
        check_eq("lat_vout_t2", int'(validout), 1);
        check_eq("lat_dout_t2", int'(dout), 0);
        cyc(1'b0, 8'h00);
        check_eq("lat_vout_t3", int'(validout), 0);
        do_reset(2);

        fill(8'h80);
        run_frame("flat", 0, 0, 0);

        fill(8'h40); set_px(2, 3, 8'hC0);
        run_frame("peak", 0, 1, 2 * W + 3 + W + 1);

        fill(8'h40); set_px(2, 3, 8'h50);
        run_frame("thr_eq", 0, 0, 0);
        fill(8'h40); set_px(2, 3, 8'h51);
        run_frame("thr_p1", 0, 1, 28);
        fill(8'hF0); set_px(2, 3, 8'hFF);
        run_frame("thr_wrap", 0, 0, 0);

        fill(8'h40); set_px(0, 3, 8'hC0);
        run_frame("border_top", 0, 0, 0);
        fill(8'h40); set_px(2, 7, 8'hC0);
        run_frame("border_right", 0, 0, 0);

        fill(8'h40); set_px(2, 3, 8'hC0);
        run_frame("gaps", 30, 1, 28);

        // Two back-to-back peak frames: the peaks appear one frame (N outputs) apart.
        base = out_count;
        nff  = ff_abs.size();
        send_frame(0);
        send_frame(0);
        idle(4);
        check_eq("b2b_ffs", ff_abs.size() - nff, 2);
        if (ff_abs.size() >= nff + 2) begin
            check_eq("b2b_first", ff_abs[nff] - base, 28);
            check_eq("b2b_spacing", ff_abs[nff + 1] - ff_abs[nff], N);
        end

        // Reset mid-frame; the next pixel must be treated as (0,0).
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom));
        do_reset(2);
        idle(3);
        run_frame("midrst", 0, 1, 28);

        // Random content with random gaps, checked pixel-by-pixel by the model.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) img[i] = 8'($urandom);
            send_frame(20);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
